pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable (`*_Wr`) and flush (`*_Flush`) inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers and the PC write enable. Resolves, by fixed priority:
- MEM-stage exceptions
- I/D-cache busy stalls
- multi-cycle divide occupancy in EXE
- EXE-stage taken branches
- load-use hazards between EXE and ID

---
 rtl/pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central stall/flush sequencer for a 5-stage pipeline. It drives the write
// enables and flushes of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers
// and the PC write enable. Conflicts are resolved by fixed priority, highest
// first: MEM exception, I/D cache busy, divide occupancy in EXE, taken branch
// in EXE, load-use hazard between EXE and ID.
//
// Parameters:
//   DIV_CYCLES       cycles the divider needs after Div_Start (2..63)
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   ID_rs, ID_rt     source register fields of the instruction in ID
//   ID_RegsReadSel   bit0: ID reads rs, bit1: ID reads rt
//   EXE_Dst          destination register of the EXE instruction
//   EXE_RegWr        EXE instruction writes a GPR
//   EXE_IsLoad       EXE instruction is a load
//   EXE_IsDiv        EXE instruction is DIV/DIVU
//   EXE_BranchTaken  branch/jump in EXE resolved taken
//   MEM_ExceptValid  exception for the MEM instruction
//   ICache_Busy      instruction fetch not complete
//   DCache_Busy      data access not complete
//   PC_Wr .. WB_Wr   stage register write enables
//   ID_Flush .. WB_Flush  stage register flushes
//   Div_Start        one-cycle divider start pulse
//   Div_Abort        one-cycle in-flight divide cancel pulse
//   Perf_StallCnt    saturating count of cycles with PC_Wr=0
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, Perf_StallCnt is a live counter;
//                       otherwise it is tied to zero and no counter is built.

module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [1:0]  ID_RegsReadSel,
  input  logic [4:0]  EXE_Dst,
  input  logic        EXE_RegWr,
  input  logic        EXE_IsLoad,
  input  logic        EXE_IsDiv,
  input  logic        EXE_BranchTaken,
  input  logic        MEM_ExceptValid,
  input  logic        ICache_Busy,
  input  logic        DCache_Busy,
  output logic        PC_Wr,
  output logic        ID_Wr,
  output logic        EXE_Wr,
  output logic        MEM_Wr,
  output logic        WB_Wr,
  output logic        ID_Flush,
  output logic        EXE_Flush,
  output logic        MEM_Flush,
  output logic        WB_Flush,
  output logic        Div_Start,
  output logic        Div_Abort,
  output logic [31:0] Perf_StallCnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV      = 2'd1,
    S_DIV_DONE = 2'd2
  } state_e;

  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] div_cnt_q, div_cnt_d;

  logic cache_busy;
  logic load_use;
  logic div_hold;

  assign cache_busy = ICache_Busy | DCache_Busy;

  assign load_use = EXE_IsLoad & EXE_RegWr & (EXE_Dst != 5'd0) &
                    ((ID_RegsReadSel[0] & (ID_rs == EXE_Dst)) |
                     (ID_RegsReadSel[1] & (ID_rt == EXE_Dst)));

  // The divide holds EXE both on its launch cycle and while it is running.
  assign div_hold = (state_q == S_DIV) | ((state_q == S_IDLE) & EXE_IsDiv);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (MEM_ExceptValid) begin
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        div_cnt_d = 6'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // A cache stall outranks the divide, so the launch waits for it.
          if (!cache_busy && EXE_IsDiv) begin
            state_d   = S_DIV;
            div_cnt_d = DIV_CNT_INIT;
          end
        end
        S_DIV: begin
          // The divider keeps running through cache stalls.
          if (div_cnt_q == 6'd0) state_d   = S_DIV_DONE;
          else                   div_cnt_d = div_cnt_q - 6'd1;
        end
        S_DIV_DONE: begin
          // The finished DIV can only leave EXE once the pipe moves again.
          if (!cache_busy) state_d = S_IDLE;
        end
        default: begin
          state_d   = S_IDLE;
          div_cnt_d = 6'd0;
        end
      endcase
    end
  end

  // ---- output logic ----
  always_comb begin
    PC_Wr     = 1'b1;
    ID_Wr     = 1'b1;
    EXE_Wr    = 1'b1;
    MEM_Wr    = 1'b1;
    WB_Wr     = 1'b1;
    ID_Flush  = 1'b0;
    EXE_Flush = 1'b0;
    MEM_Flush = 1'b0;
    WB_Flush  = 1'b0;
    Div_Start = 1'b0;
    Div_Abort = 1'b0;
    if (!rst) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Wr    = 1'b0;
      MEM_Wr    = 1'b0;
      WB_Wr     = 1'b0;
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
      WB_Flush  = 1'b1;
    end else if (MEM_ExceptValid) begin
      // PC stays writable so the handler address is loaded.
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
      WB_Flush  = 1'b1;
      Div_Abort = (state_q != S_IDLE);
    end else if (cache_busy) begin
      PC_Wr  = 1'b0;
      ID_Wr  = 1'b0;
      EXE_Wr = 1'b0;
      MEM_Wr = 1'b0;
      WB_Wr  = 1'b0;
    end else if (div_hold) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Wr    = 1'b0;
      MEM_Flush = 1'b1;
      Div_Start = (state_q == S_IDLE);
    end else if (state_q == S_DIV_DONE) begin
      // Departing DIV: plain advance, no branch/load-use in EXE to act on.
    end else if (EXE_BranchTaken) begin
      ID_Flush = 1'b1;
    end else if (load_use) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (!PC_Wr) perf_cnt_d = sat_inc32(perf_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cnt_q <= 32'd0;
    else      perf_cnt_q <= perf_cnt_d;
  end

  assign Perf_StallCnt = perf_cnt_q;
`else
  assign Perf_StallCnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_CYCLES=4.
// Output vector order: {PC,ID,EXE,MEM,WB}_Wr, {ID,EXE,MEM,WB}_Flush, Div_Start, Div_Abort.

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs, ID_rt, EXE_Dst;
  logic [1:0]  ID_RegsReadSel;
  logic        EXE_RegWr, EXE_IsLoad, EXE_IsDiv, EXE_BranchTaken;
  logic        MEM_ExceptValid, ICache_Busy, DCache_Busy;
  logic        PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
  logic        ID_Flush, EXE_Flush, MEM_Flush, WB_Flush;
  logic        Div_Start, Div_Abort;
  logic [31:0] Perf_StallCnt;
  logic [10:0] ov;

  int errs   = 0;
  int checks = 0;

  localparam logic [10:0] DFLT    = 11'b11111_0000_00;
  localparam logic [10:0] RSTV    = 11'b00000_1111_00;
  localparam logic [10:0] STALL   = 11'b00000_0000_00;
  localparam logic [10:0] DIVS    = 11'b00011_0010_10;
  localparam logic [10:0] DIVB    = 11'b00011_0010_00;
  localparam logic [10:0] BR      = 11'b11111_1000_00;
  localparam logic [10:0] LU      = 11'b00111_0100_00;
  localparam logic [10:0] EXC     = 11'b11111_1111_00;
  localparam logic [10:0] EXC_ABT = 11'b11111_1111_01;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] PERF10 = 32'd10;
  localparam logic [31:0] PERF12 = 32'd12;
`else
  localparam logic [31:0] PERF10 = 32'd0;
  localparam logic [31:0] PERF12 = 32'd0;
`endif

  always #5 clk = ~clk;

  assign ov = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
               ID_Flush, EXE_Flush, MEM_Flush, WB_Flush, Div_Start, Div_Abort};

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_RegsReadSel(ID_RegsReadSel),
    .EXE_Dst(EXE_Dst), .EXE_RegWr(EXE_RegWr), .EXE_IsLoad(EXE_IsLoad),
    .EXE_IsDiv(EXE_IsDiv), .EXE_BranchTaken(EXE_BranchTaken),
    .MEM_ExceptValid(MEM_ExceptValid), .ICache_Busy(ICache_Busy),
    .DCache_Busy(DCache_Busy),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
    .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush),
    .WB_Flush(WB_Flush), .Div_Start(Div_Start), .Div_Abort(Div_Abort),
    .Perf_StallCnt(Perf_StallCnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clr();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_RegsReadSel = 2'b00; EXE_Dst = 5'd0;
    EXE_RegWr = 1'b0; EXE_IsLoad = 1'b0; EXE_IsDiv = 1'b0; EXE_BranchTaken = 1'b0;
    MEM_ExceptValid = 1'b0; ICache_Busy = 1'b0; DCache_Busy = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string tag, input logic [10:0] exp);
    #1;
    chk(tag, {21'd0, ov}, {21'd0, exp});
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #3;
    chk("reset_outputs", {21'd0, ov}, {21'd0, RSTV});
    chk("reset_perf", Perf_StallCnt, 32'd0);
    rst = 1'b1;

    // stall counter: 10 ICache stall edges, then async reset mid-count
    next(); ICache_Busy = 1'b1; probe("icache_stall", STALL);
    repeat (10) next();
    ICache_Busy = 1'b0; #1;
    chk("perf_10", Perf_StallCnt, PERF10);
    ICache_Busy = 1'b1;
    next(); next();
    chk("perf_12", Perf_StallCnt, PERF12);
    #2 rst = 1'b0; #1;
    chk("perf_async_rst", Perf_StallCnt, 32'd0);
    chk("outputs_async_rst", {21'd0, ov}, {21'd0, RSTV});
    #1 rst = 1'b1; ICache_Busy = 1'b0;

    // load-use
    next(); clr(); probe("idle_default", DFLT);
    next(); EXE_IsLoad = 1'b1; EXE_RegWr = 1'b1; EXE_Dst = 5'd5;
    ID_rs = 5'd5; ID_RegsReadSel = 2'b01; probe("lu_rs", LU);
    next(); clr(); probe("lu_one_bubble", DFLT);
    next(); EXE_IsLoad = 1'b1; EXE_RegWr = 1'b1; EXE_Dst = 5'd9;
    ID_rt = 5'd9; ID_rs = 5'd3; ID_RegsReadSel = 2'b10; probe("lu_rt", LU);
    ID_RegsReadSel = 2'b00; ID_rs = 5'd9; probe("lu_nosel", DFLT);
    EXE_Dst = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_RegsReadSel = 2'b11;
    probe("lu_r0", DFLT);
    EXE_Dst = 5'd7; ID_rs = 5'd7; EXE_RegWr = 1'b0; probe("lu_noregwr", DFLT);
    EXE_RegWr = 1'b1; EXE_IsLoad = 1'b0; probe("lu_notload", DFLT);

    // branch, and branch outranking load-use
    next(); clr(); EXE_BranchTaken = 1'b1; probe("branch", BR);
    EXE_IsLoad = 1'b1; EXE_RegWr = 1'b1; EXE_Dst = 5'd4; ID_rs = 5'd4;
    ID_RegsReadSel = 2'b01; probe("branch_over_lu", BR);

    // exception in IDLE outranks cache busy and divide launch
    next(); clr(); EXE_IsDiv = 1'b1; MEM_ExceptValid = 1'b1; ICache_Busy = 1'b1;
    probe("exc_idle", EXC);
    next(); clr(); probe("exc_idle_no_div", DFLT);

    // divide, DIV_CYCLES=4, IsDiv held
    next(); EXE_IsDiv = 1'b1; probe("div_c0", DIVS);
    for (int i = 1; i <= 4; i++) begin
      next(); probe($sformatf("div_c%0d", i), DIVB);
    end
    next(); probe("div_c5_adv", DFLT);
    next(); probe("div_c6_idle_restart", DIVS);
    next(); probe("div2_c1", DIVB);
    next(); MEM_ExceptValid = 1'b1; probe("div2_c2_abort", EXC_ABT);
    next(); clr(); probe("div2_after_abort", DFLT);

    // divide with DCache stall over cycles 3..8
    next(); EXE_IsDiv = 1'b1; probe("dstall_c0", DIVS);
    next(); probe("dstall_c1", DIVB);
    next(); probe("dstall_c2", DIVB);
    for (int i = 3; i <= 8; i++) begin
      next(); DCache_Busy = 1'b1; probe($sformatf("dstall_c%0d", i), STALL);
    end
    next(); DCache_Busy = 1'b0; probe("dstall_c9_adv", DFLT);
    next(); probe("dstall_c10_restart", DIVS);
    next(); MEM_ExceptValid = 1'b1; probe("dstall_abort", EXC_ABT);
    next(); clr(); probe("dstall_idle", DFLT);

    // branch held under ICache stall
    next(); EXE_BranchTaken = 1'b1; ICache_Busy = 1'b1; probe("br_icache0", STALL);
    next(); probe("br_icache1", STALL);
    next(); ICache_Busy = 1'b0; probe("br_released", BR);
    next(); clr(); probe("br_done", DFLT);

    // async reset mid-divide: no abort, back to IDLE
    next(); EXE_IsDiv = 1'b1; probe("rdiv_c0", DIVS);
    next(); probe("rdiv_c1", DIVB);
    #2 rst = 1'b0; #1;
    chk("rdiv_reset_no_abort", {21'd0, ov}, {21'd0, RSTV});
    #1 rst = 1'b1; EXE_IsDiv = 1'b0;
    probe("rdiv_idle", DFLT);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
